// File: rtl/rom_ctrl_pkg.sv
// Shared types, defaults and helpers for the rom read-port arbiter and its
// response formatter.
package rom_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } size_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam logic [15:0] ROM_BASE_DEF    = 16'h8000;
    localparam int          ROM_LATENCY_DEF = 1;
    localparam int          STARVE_MAX_DEF  = 4;

    // Reserved size reports 4 so the range check stays well defined; it is
    // flagged as an error separately.
    function automatic logic [2:0] nbytes(input size_t size);
        logic [2:0] n;
        unique case (size)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rom_resp_format.sv
// Little-endian load formatter: selects byte/half/word from q0..q3 and
// zero- or sign-extends to 32 bits.
module rom_resp_format
    import rom_ctrl_pkg::*;
(
    input  logic [7:0]  q0,
    input  logic [7:0]  q1,
    input  logic [7:0]  q2,
    input  logic [7:0]  q3,
    input  size_t       size,
    input  logic        sext,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        unique case (size)
            SZ_B:    data = {{24{sext & q0[7]}}, q0};
            SZ_H:    data = {{16{sext & q1[7]}}, q1, q0};
            SZ_W:    data = {q3, q2, q1, q0};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single rom read port between instruction fetch (IF) and the
// load/store unit (LS); one transaction outstanding at a time.
module rom_port_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] ROM_BASE    = ADDR_W'(ROM_BASE_DEF),
    parameter int                ROM_LATENCY = ROM_LATENCY_DEF,
    parameter int                STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [31:0]       if_resp_data,
    output logic              if_resp_err,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [1:0]        ls_req_size,
    input  logic              ls_req_signed,
    output logic              ls_resp_valid,
    input  logic              ls_resp_ready,
    output logic [31:0]       ls_resp_data,
    output logic              ls_resp_err,

    output logic [ADDR_W-1:0] rom_a,
    output logic              rom_re,
    input  logic [7:0]        rom_q0,
    input  logic [7:0]        rom_q1,
    input  logic [7:0]        rom_q2,
    input  logic [7:0]        rom_q3
);

    // Handshake rule for every channel: a transfer happens on a rising edge
    // where valid and ready are both high; a requester may drop valid at any
    // time before that edge, and a response is held stable until taken.

    localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    state_t            state, state_next;
    logic [SW-1:0]     starve_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] addr_r;
    size_t             size_r;
    logic              sext_r;
    req_id_t           id_r;
    logic              err_r;
    logic [31:0]       data_r;
    logic              live_r;

    logic              starve_hit;
    logic              grant_ls;
    logic              grant_if;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    size_t             sel_size;
    logic              sel_sext;
    logic [ADDR_W:0]   end_addr;
    logic              req_err;
    logic              lat_done;
    logic              resp_ready_sel;
    logic [31:0]       fmt_data;
    logic [31:0]       resp_data;

    // Grant decision: LS wins unless IF has waited STARVE_MAX LS grants.
    always_comb begin
        starve_hit = if_req_valid && (starve_cnt == SW'(STARVE_MAX));
        grant_ls   = rst_n && (state == IDLE) && ls_req_valid && !starve_hit;
        grant_if   = rst_n && (state == IDLE) && if_req_valid && !grant_ls;
        accept     = grant_ls || grant_if;
    end

    assign ls_req_ready = grant_ls;
    assign if_req_ready = grant_if;

    always_comb begin
        sel_addr = grant_ls ? ls_req_addr : if_req_addr;
        sel_size = grant_ls ? size_t'(ls_req_size) : SZ_W;
        sel_sext = grant_ls && ls_req_signed;
        end_addr = {1'b0, sel_addr} + (ADDR_W + 1)'(nbytes(sel_size))
                   - (ADDR_W + 1)'(1);
        req_err  = (sel_addr < ROM_BASE) || (sel_size == SZ_RSVD) ||
                   end_addr[ADDR_W];
    end

    assign lat_done       = (lat_cnt == LAT_W'(ROM_LATENCY - 1));
    assign resp_ready_sel = (id_r == REQ_IF) ? if_resp_ready : ls_resp_ready;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = req_err ? RESP : READ;
            READ: if (lat_done) state_next = RESP;
            RESP: if (resp_ready_sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            addr_r     <= '0;
            size_r     <= SZ_W;
            sext_r     <= 1'b0;
            id_r       <= REQ_IF;
            err_r      <= 1'b0;
            data_r     <= '0;
            live_r     <= 1'b0;
        end else begin
            state <= state_next;

            if (!if_req_valid || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_ls) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (accept) begin
                id_r    <= grant_ls ? REQ_LS : REQ_IF;
                size_r  <= sel_size;
                sext_r  <= sel_sext;
                err_r   <= req_err;
                data_r  <= '0;
                live_r  <= 1'b0;
                lat_cnt <= '0;
                if (!req_err) addr_r <= sel_addr;
            end

            if (state == READ) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
                if (lat_done) live_r <= 1'b1;
            end

            // The rom updates q on the edge that ends READ, so the first RESP
            // cycle shows the formatter directly; that value is then held.
            if (state == RESP && live_r) begin
                data_r <= fmt_data;
                live_r <= 1'b0;
            end
        end
    end

    rom_resp_format u_fmt (
        .q0   (rom_q0),
        .q1   (rom_q1),
        .q2   (rom_q2),
        .q3   (rom_q3),
        .size (size_r),
        .sext (sext_r),
        .data (fmt_data)
    );

    assign resp_data = live_r ? fmt_data : data_r;

    assign rom_a  = addr_r;
    assign rom_re = (state == READ);

    assign if_resp_valid = (state == RESP) && (id_r == REQ_IF);
    assign ls_resp_valid = (state == RESP) && (id_r == REQ_LS);
    assign if_resp_err   = if_resp_valid && err_r;
    assign ls_resp_err   = ls_resp_valid && err_r;
    assign if_resp_data  = if_resp_valid ? resp_data : '0;
    assign ls_resp_data  = ls_resp_valid ? resp_data : '0;

endmodule
